// File: rtl/xm_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// xm_tx_arbiter_pkg
//   Shared definitions for the xm_top TX arbiter slice:
//     arb_state_t : frame-level arbiter FSM states (ST_IDLE, ST_BUSY)
//     src_w()     : width of a source index for a given requester count
// ---------------------------------------------------------------------------
package xm_tx_arbiter_pkg;

    // ST_IDLE doubles as the one-cycle arbitration slot between frames.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Never returns 0 so a single-source build still has a legal index port.
    function automatic int unsigned src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xm_tx_arbiter_rsp_fifo.sv
// ---------------------------------------------------------------------------
// xm_arb_rsp_fifo
//   Synchronous FIFO holding the source index of every granted frame until
//   xm_top returns its tx_status response. No bypass: a pushed entry is
//   visible at the head one cycle after the push at the earliest.
// Ports
//   clk        in   clock
//   rst_n      in   synchronous active-low reset (empties the FIFO)
//   push       in   write push_data (ignored while full)
//   push_data  in   WIDTH  source index to store
//   pop        in   drop the head entry (ignored while empty)
//   head       out  WIDTH  oldest entry
//   count      out  number of stored entries (0..DEPTH)
//   empty      out  count == 0
// ---------------------------------------------------------------------------
module xm_arb_rsp_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/xm_tx_arbiter.sv
// ---------------------------------------------------------------------------
// xm_tx_arbiter
//   Frame-level round-robin arbiter sharing the single xm_top AXIS TX port
//   among NUM_SRC requesters. A grant lasts for a whole frame (until the
//   beat with last=1 is accepted). Frame responses from xm_top come back in
//   issue order and are steered to the source that sent the frame.
// Ports
//   tx_user_clk_i / tx_user_rst_n_i   clock, synchronous active-low reset
//   s_tx_data_i/vldb_i/valid_i/last_i/user_i   per-source AXIS inputs,
//                                              source k in slice k
//   s_tx_ready_o       per-source ready (only the granted source, in BUSY)
//   s_tx_rsp_valid_o   one-hot response strobe to the originating source
//   s_tx_status_o      response status, qualified by s_tx_rsp_valid_o
//   m_tx_*_o / m_tx_ready_i           shared AXIS towards xm_top
//   m_tx_status_i / m_tx_rsp_valid_i  per-frame response from xm_top
//   grant_id_o         current / last granted source index
//   busy_o             frame in progress
//   rsp_err_o          sticky: response seen with no frame outstanding
// ---------------------------------------------------------------------------
module xm_tx_arbiter
    import xm_tx_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_SRC   = 2,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned VLDB_W    = 2,
    parameter  int unsigned RSP_DEPTH = 4,
    localparam int unsigned SRC_W     = src_w(NUM_SRC)
) (
    input  logic                      tx_user_clk_i,
    input  logic                      tx_user_rst_n_i,
    input  logic [NUM_SRC*DATA_W-1:0] s_tx_data_i,
    input  logic [NUM_SRC*VLDB_W-1:0] s_tx_vldb_i,
    input  logic [NUM_SRC-1:0]        s_tx_valid_i,
    output logic [NUM_SRC-1:0]        s_tx_ready_o,
    input  logic [NUM_SRC-1:0]        s_tx_last_i,
    input  logic [NUM_SRC-1:0]        s_tx_user_i,
    output logic [NUM_SRC-1:0]        s_tx_rsp_valid_o,
    output logic                      s_tx_status_o,
    output logic [DATA_W-1:0]         m_tx_data_o,
    output logic [VLDB_W-1:0]         m_tx_vldb_o,
    output logic                      m_tx_valid_o,
    output logic                      m_tx_last_o,
    output logic                      m_tx_user_o,
    input  logic                      m_tx_ready_i,
    input  logic                      m_tx_status_i,
    input  logic                      m_tx_rsp_valid_i,
    output logic [SRC_W-1:0]          grant_id_o,
    output logic                      busy_o,
    output logic                      rsp_err_o
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

    arb_state_t         state;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   pick;
    logic               any_req;
    logic               can_grant;
    logic               grant_now;
    logic               last_xfer;

    logic [CNT_W-1:0]   rsp_count;
    logic [SRC_W-1:0]   rsp_head;
    logic               rsp_empty;

    logic [NUM_SRC-1:0] rsp_valid;
    logic               rsp_status;
    logic               rsp_err;

    // -----------------------------------------------------------------------
    // Round-robin picker. The request vector is rotated so that bit j holds
    // source (rr_ptr + 1 + j) mod NUM_SRC; the lowest set bit wins and is
    // mapped back to a source index.
    // -----------------------------------------------------------------------
    logic [NUM_SRC-1:0] req_rot;
    logic [SRC_W:0]     base;
    logic [SRC_W:0]     sum;
    logic [SRC_W-1:0]   offset;

    always_comb begin
        base    = {1'b0, rr_ptr} + {{SRC_W{1'b0}}, 1'b1};
        req_rot = NUM_SRC'({s_tx_valid_i, s_tx_valid_i} >> base);
        offset  = '0;
        for (int unsigned j = NUM_SRC; j > 0; j--) begin
            if (req_rot[j-1]) begin
                offset = SRC_W'(j - 1);
            end
        end
        sum = base + {1'b0, offset};
        if (sum >= (SRC_W+1)'(NUM_SRC)) begin
            sum = sum - (SRC_W+1)'(NUM_SRC);
        end
        pick = sum[SRC_W-1:0];
    end

    assign any_req   = |s_tx_valid_i;
    // Registered count only: a pop in this cycle frees a slot for next cycle.
    assign can_grant = (rsp_count < CNT_W'(RSP_DEPTH));
    assign grant_now = (state == ST_IDLE) && any_req && can_grant;
    assign last_xfer = m_tx_valid_o && m_tx_ready_i && m_tx_last_o;

    // -----------------------------------------------------------------------
    // Arbiter FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge tx_user_clk_i) begin
        if (!tx_user_rst_n_i) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= SRC_W'(NUM_SRC - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        grant  <= pick;
                        rr_ptr <= pick;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (last_xfer) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign grant_id_o = grant;
    assign busy_o     = (state == ST_BUSY);

    // -----------------------------------------------------------------------
    // Pass-through of the granted source while BUSY; everything quiet in IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        m_tx_data_o  = '0;
        m_tx_vldb_o  = '0;
        m_tx_valid_o = 1'b0;
        m_tx_last_o  = 1'b0;
        m_tx_user_o  = 1'b0;
        s_tx_ready_o = '0;
        if (state == ST_BUSY) begin
            m_tx_data_o         = s_tx_data_i[32'(grant)*DATA_W +: DATA_W];
            m_tx_vldb_o         = s_tx_vldb_i[32'(grant)*VLDB_W +: VLDB_W];
            m_tx_valid_o        = s_tx_valid_i[grant];
            m_tx_last_o         = s_tx_last_i[grant];
            m_tx_user_o         = s_tx_user_i[grant];
            s_tx_ready_o[grant] = m_tx_ready_i;
        end
    end

    // -----------------------------------------------------------------------
    // Outstanding-frame FIFO: pushed at grant, popped per response.
    // -----------------------------------------------------------------------
    xm_arb_rsp_fifo #(
        .WIDTH (SRC_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (tx_user_clk_i),
        .rst_n     (tx_user_rst_n_i),
        .push      (grant_now),
        .push_data (pick),
        .pop       (m_tx_rsp_valid_i),
        .head      (rsp_head),
        .count     (rsp_count),
        .empty     (rsp_empty)
    );

    // -----------------------------------------------------------------------
    // Response demux: one-cycle registered strobe to the head source.
    // -----------------------------------------------------------------------
    always_ff @(posedge tx_user_clk_i) begin
        if (!tx_user_rst_n_i) begin
            rsp_valid  <= '0;
            rsp_status <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (m_tx_rsp_valid_i) begin
                if (rsp_empty) begin
                    rsp_err <= 1'b1;
                end else begin
                    rsp_valid[rsp_head] <= 1'b1;
                    rsp_status          <= m_tx_status_i;
                end
            end
        end
    end

    assign s_tx_rsp_valid_o = rsp_valid;
    assign s_tx_status_o    = rsp_status;
    assign rsp_err_o        = rsp_err;

endmodule

// File: tb/tb_xm_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xm_tx_arbiter
//   Bench for xm_tx_arbiter with three sources. Sources are frame
//   generators fed from per-source queues of frame lengths; a transaction-
//   level model (busy flag, granted index, RR pointer, queue of outstanding
//   frames) predicts every output each cycle. Directed scenarios at the
//   start also pin exact cycle-level values with literals.
// ---------------------------------------------------------------------------
module tb_xm_tx_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned VW = 2;
    localparam int unsigned D  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*DW-1:0] s_data = '0;
    logic [N*VW-1:0] s_vldb = '0;
    logic [N-1:0]    s_valid = '0;
    logic [N-1:0]    s_ready;
    logic [N-1:0]    s_last = '0;
    logic [N-1:0]    s_user = '0;
    logic [N-1:0]    s_rsp_valid;
    logic            s_status;
    logic [DW-1:0]   m_data;
    logic [VW-1:0]   m_vldb;
    logic            m_valid;
    logic            m_last;
    logic            m_user;
    logic            m_ready = 1'b1;
    logic            m_status = 1'b0;
    logic            m_rsp = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            rsp_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    xm_tx_arbiter #(
        .NUM_SRC   (N),
        .DATA_W    (DW),
        .VLDB_W    (VW),
        .RSP_DEPTH (D)
    ) dut (
        .tx_user_clk_i    (clk),
        .tx_user_rst_n_i  (rst_n),
        .s_tx_data_i      (s_data),
        .s_tx_vldb_i      (s_vldb),
        .s_tx_valid_i     (s_valid),
        .s_tx_ready_o     (s_ready),
        .s_tx_last_i      (s_last),
        .s_tx_user_i      (s_user),
        .s_tx_rsp_valid_o (s_rsp_valid),
        .s_tx_status_o    (s_status),
        .m_tx_data_o      (m_data),
        .m_tx_vldb_o      (m_vldb),
        .m_tx_valid_o     (m_valid),
        .m_tx_last_o      (m_last),
        .m_tx_user_o      (m_user),
        .m_tx_ready_i     (m_ready),
        .m_tx_status_i    (m_status),
        .m_tx_rsp_valid_i (m_rsp),
        .grant_id_o       (grant_id),
        .busy_o           (busy),
        .rsp_err_o        (rsp_err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- source frame generators ----------------
    int unsigned frames [N][$];
    bit          active [N];
    int unsigned flen   [N];
    int unsigned beat   [N];
    int unsigned seq    [N];
    bit [N-1:0]  xfer = '0;
    bit          gen_clear = 1'b1;
    int unsigned bubble_pct = 0;

    task automatic gen_update();
        for (int k = 0; k < N; k++) begin
            if (gen_clear) begin
                active[k] = 1'b0;
                frames[k].delete();
                seq[k] = 0;
            end else if (xfer[k]) begin
                seq[k]++;
                beat[k]++;
                if (beat[k] == flen[k]) active[k] = 1'b0;
            end
            if (!active[k] && frames[k].size() > 0) begin
                flen[k]   = frames[k].pop_front();
                beat[k]   = 0;
                active[k] = 1'b1;
            end
            s_valid[k]           = active[k] && ($urandom_range(99) >= bubble_pct);
            s_last[k]            = active[k] && (beat[k] == flen[k] - 1);
            s_data[k*DW +: DW]   = {8'hA0 + 8'(k), 24'(seq[k])};
            s_vldb[k*VW +: VW]   = 2'(seq[k] + k);
            s_user[k]            = seq[k][2];
        end
        gen_clear = 1'b0;
        xfer      = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        gen_update();
    endtask

    // ---------------- behavioural model ----------------
    bit          mb_busy  = 1'b0;
    int unsigned mb_grant = 0;
    int unsigned mb_ptr   = N - 1;
    int unsigned mq[$];
    logic [N-1:0] mb_rspv = '0;
    logic        mb_st    = 1'b0;
    logic        mb_err   = 1'b0;

    function automatic int unsigned rr_pick(input int unsigned ptr, input logic [N-1:0] v);
        for (int unsigned i = 1; i <= N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return ptr;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] er;
        int unsigned  cnt0;
        #1;
        er = '0;
        if (mb_busy) er[mb_grant] = m_ready;
        check("grant_id", grant_id, mb_grant);
        check("busy", busy, mb_busy);
        check("m_valid", m_valid, mb_busy ? s_valid[mb_grant] : 1'b0);
        if (mb_busy) begin
            check("m_data", m_data, s_data[mb_grant*DW +: DW]);
            check("m_vldb", m_vldb, s_vldb[mb_grant*VW +: VW]);
            check("m_last", m_last, s_last[mb_grant]);
            check("m_user", m_user, s_user[mb_grant]);
        end
        check("s_ready", s_ready, er);
        check("rsp_valid", s_rsp_valid, mb_rspv);
        if (mb_rspv != '0) check("rsp_status", s_status, mb_st);
        check("rsp_err", rsp_err, mb_err);

        xfer      = rst_n ? (s_valid & er) : '0;
        gen_clear = !rst_n;

        if (!rst_n) begin
            mb_busy  = 1'b0;
            mb_grant = 0;
            mb_ptr   = N - 1;
            mq.delete();
            mb_rspv  = '0;
            mb_st    = 1'b0;
            mb_err   = 1'b0;
        end else begin
            cnt0    = mq.size();
            mb_rspv = '0;
            if (m_rsp) begin
                if (cnt0 > 0) begin
                    mb_rspv[mq.pop_front()] = 1'b1;
                    mb_st = m_status;
                end else begin
                    mb_err = 1'b1;
                end
            end
            if (!mb_busy) begin
                if (s_valid != '0 && cnt0 < D) begin
                    mb_grant = rr_pick(mb_ptr, s_valid);
                    mb_ptr   = mb_grant;
                    mq.push_back(mb_grant);
                    mb_busy  = 1'b1;
                end
            end else if (s_valid[mb_grant] && m_ready && s_last[mb_grant]) begin
                mb_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset
        tick();
        tick(); rst_n = 1'b1; frames[0].push_back(3); #2;
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_grant", grant_id, 0);
        check("rst_err", rsp_err, 0);
        check("rst_rsp", s_rsp_valid, 0);
        check("rst_ready", s_ready, 0);

        // single source, 3-beat frame
        tick(); #2;
        check("s1_wait_busy", busy, 0);
        check("s1_wait_valid", m_valid, 0);
        tick(); #2;
        check("s1_grant", grant_id, 0);
        check("s1_busy", busy, 1);
        check("s1_beat0", m_data, 32'hA000_0000);
        tick(); #2;
        check("s1_beat1", m_data, 32'hA000_0001);
        tick(); #2;
        check("s1_last", m_last, 1);
        check("s1_beat2", m_data, 32'hA000_0002);
        tick(); m_rsp = 1'b1; m_status = 1'b1; #2;
        check("s1_idle", busy, 0);
        tick(); m_rsp = 1'b0;
        repeat (3) begin
            frames[0].push_back(2);
            frames[1].push_back(2);
        end
        #2;
        check("rsp0_route", s_rsp_valid, 3'b001);
        check("rsp0_status", s_status, 1);

        // two sources alternating, FIFO fills after four grants
        tick(); #2;
        tick(); #2;
        check("alt_g1", grant_id, 1);
        check("alt_busy1", busy, 1);
        tick();
        tick(); #2;
        check("alt_gap", busy, 0);
        tick(); #2;
        check("alt_g2", grant_id, 0);
        tick(); tick();
        tick(); #2;
        check("alt_g3", grant_id, 1);
        tick(); tick();
        tick(); #2;
        check("alt_g4", grant_id, 0);
        repeat (3) tick();
        tick(); m_rsp = 1'b1; m_status = 1'b1; #2;
        check("full_stall", busy, 0);
        tick(); m_rsp = 1'b1; m_status = 1'b0; #2;
        check("full_rsp_busy", busy, 0);
        check("rsp1_route", s_rsp_valid, 3'b010);
        check("rsp1_status", s_status, 1);
        tick(); m_rsp = 1'b0; #2;
        check("full_regrant_busy", busy, 1);
        check("full_regrant_id", grant_id, 1);
        check("rsp2_route", s_rsp_valid, 3'b001);
        check("rsp2_status", s_status, 0);
        repeat (4) tick();

        // drain to two outstanding, then reset mid-frame
        tick(); m_rsp = 1'b1; frames[2].push_back(4); #2;
        tick(); m_rsp = 1'b1; #2;
        check("drain_rsp_a", s_rsp_valid, 3'b010);
        tick(); m_rsp = 1'b1; #2;
        check("drain_grant2", grant_id, 2);
        check("drain_rsp_b", s_rsp_valid, 3'b001);
        tick(); m_rsp = 1'b0; rst_n = 1'b0; #2;
        check("pre_rst_busy", busy, 1);
        check("drain_rsp_c", s_rsp_valid, 3'b010);
        tick(); rst_n = 1'b1; m_rsp = 1'b1; #2;
        check("midrst_busy", busy, 0);
        check("midrst_valid", m_valid, 0);
        check("midrst_grant", grant_id, 0);
        check("midrst_ready", s_ready, 0);
        tick(); m_rsp = 1'b0; #2;
        check("spurious_err", rsp_err, 1);
        check("spurious_nostrobe", s_rsp_valid, 0);
        tick(); #2;
        check("err_sticky", rsp_err, 1);

        // randomized traffic: bubbles, backpressure, responses, resets
        bubble_pct = 25;
        repeat (5000) begin
            tick();
            m_ready  = ($urandom_range(99) < 70);
            m_status = 1'($urandom_range(1));
            m_rsp    = (mq.size() > 0 && $urandom_range(99) < 30) || ($urandom_range(999) < 5);
            rst_n    = ($urandom_range(999) >= 3);
            for (int k = 0; k < N; k++) begin
                if (!active[k] && frames[k].size() == 0 && $urandom_range(99) < 20)
                    frames[k].push_back($urandom_range(5, 1));
            end
        end
        rst_n = 1'b1;
        m_rsp = 1'b0;
        repeat (3) tick();
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
